// File: rtl/fifo_credit_pkg.sv
// Shared types and helpers for the credit-based fifo sender.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: credit_state_t (flush FSM encoding), credit_cnt_width() (width of a 0..n counter).
package fifo_credit_pkg;

   typedef enum logic [1:0] {RUN, FLUSH_WAIT, DONE} credit_state_t;

   // Bits needed to hold every value 0..n inclusive.
   function automatic int credit_cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fifo_credit_out_stage.sv
// Optional output register (valid + data) between the credit sender and the remote fifo.
// Latency: 1 cycle when REG_EN=1, 0 cycles (wires) when REG_EN=0.
// Backpressure: none; a push always lands because the sender only pushes while holding a credit.
// Ports:
//   clk, reset          clock and async active-low reset
//   i__valid, i__data   beat from the sender
//   o__valid, o__data   beat to the remote fifo; o__data holds its last value while o__valid=0
//   o__empty            1 when no beat is held in the register (always 1 in bypass mode)
module fifo_credit_out_stage #(
   parameter int DATA_WIDTH = 64,
   parameter bit REG_EN     = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i__valid,
   input  logic [DATA_WIDTH-1:0] i__data,
   output logic                  o__valid,
   output logic [DATA_WIDTH-1:0] o__data,
   output logic                  o__empty
);

   generate
      if (REG_EN) begin : g_reg
         logic                  r_valid;
         logic [DATA_WIDTH-1:0] r_data;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_valid <= 1'b0;
               r_data  <= '0;
            end else begin
               r_valid <= i__valid;
               // Data only moves with a beat so the last payload stays visible.
               if (i__valid) begin
                  r_data <= i__data;
               end
            end
         end

         assign o__valid = r_valid;
         assign o__data  = r_data;
         assign o__empty = !r_valid;
      end else begin : g_bypass
         // Clock and reset are not needed when the stage is pure wiring.
         logic w_unused_clk_rst;
         assign w_unused_clk_rst = clk & reset;

         assign o__valid = i__valid;
         assign o__data  = i__data;
         assign o__empty = 1'b1;
      end
   endgenerate

endmodule

// File: rtl/fifo_credit_sender.sv
// Credit-based sender into a remote fifo: upstream valid/ready in, valid-only push out.
// Latency: 0 cycles (combinational), 1 cycle with FIFO_CREDIT_SENDER_OUT_REG_EN defined.
// Backpressure: ready drops when credits are exhausted or a flush is in progress; never depends on valid.
// Ports:
//   clk, reset                          clock, async active-low reset
//   i__data_in_valid/i__data_in         upstream beat; o__data_in_ready accepts it
//   o__data_out_valid/o__data_out       push into the remote fifo
//   i__credit_return                    one pulse per remote dequeue
//   i__flush/o__flush_done              drain request and one-cycle completion pulse
//   o__credit_count, o__credit_error    credits held; sticky over-return flag
// Optional: FIFO_CREDIT_SENDER_OUT_REG_EN registers the output beat.
module fifo_credit_sender
   import fifo_credit_pkg::*;
#(
   parameter  int DATA_WIDTH  = 64,
   parameter  int NUM_CREDITS = 3,
   localparam int CNT_W       = credit_cnt_width(NUM_CREDITS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i__data_in_valid,
   input  logic [DATA_WIDTH-1:0] i__data_in,
   output logic                  o__data_in_ready,
   output logic                  o__data_out_valid,
   output logic [DATA_WIDTH-1:0] o__data_out,
   input  logic                  i__credit_return,
   input  logic                  i__flush,
   output logic                  o__flush_done,
   output logic [CNT_W-1:0]      o__credit_count,
   output logic                  o__credit_error
);

`ifdef FIFO_CREDIT_SENDER_OUT_REG_EN
   localparam bit OUT_REG_EN = 1'b1;
`else
   localparam bit OUT_REG_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] MAX_CRED = CNT_W'(NUM_CREDITS);
   localparam logic [CNT_W-1:0] ONE_CRED = CNT_W'(1);

   credit_state_t    r_state;
   credit_state_t    w_state_nxt;
   logic [CNT_W-1:0] r_credits;
   logic             r_error;
   logic             w_send;
   logic             w_full;
   logic             w_stage_empty;

   assign w_send = i__data_in_valid && o__data_in_ready;
   assign w_full = (r_credits == MAX_CRED);

   // Credit counter and sticky over-return flag. Send and return together cancel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_credits <= MAX_CRED;
         r_error   <= 1'b0;
      end else begin
         if (w_send && !i__credit_return) begin
            r_credits <= r_credits - ONE_CRED;
         end else if (!w_send && i__credit_return && !w_full) begin
            r_credits <= r_credits + ONE_CRED;
         end
         if (!w_send && i__credit_return && w_full) begin
            r_error <= 1'b1;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state. The drain completes only once every credit is home and
   // no beat is still sitting in the output register.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:        if (i__flush) w_state_nxt = FLUSH_WAIT;
         FLUSH_WAIT: if (w_full && w_stage_empty) w_state_nxt = DONE;
         DONE:       w_state_nxt = RUN;
         default:    w_state_nxt = RUN;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o__data_in_ready = 1'b0;
      o__flush_done    = 1'b0;
      case (r_state)
         RUN:     o__data_in_ready = (r_credits != '0);
         DONE:    o__flush_done    = 1'b1;
         default: ;
      endcase
   end

   fifo_credit_out_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_EN     (OUT_REG_EN)
   ) u_out_stage (
      .clk      (clk),
      .reset    (reset),
      .i__valid (w_send),
      .i__data  (i__data_in),
      .o__valid (o__data_out_valid),
      .o__data  (o__data_out),
      .o__empty (w_stage_empty)
   );

   assign o__credit_count = r_credits;
   assign o__credit_error = r_error;

endmodule

// File: tb/tb_fifo_credit_sender.sv
// Self-checking bench for fifo_credit_sender (NUM_CREDITS=3, DATA_WIDTH=64).
// Latency: output timing follows FIFO_CREDIT_SENDER_OUT_REG_EN when defined.
// Backpressure: upstream valid is held and the bench advances data only on accept.
module tb_fifo_credit_sender;

   localparam int DW = 64;
   localparam int NC = 3;
   localparam int CW = $clog2(NC + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          i__data_in_valid;
   logic [DW-1:0] i__data_in;
   logic          o__data_in_ready;
   logic          o__data_out_valid;
   logic [DW-1:0] o__data_out;
   logic          i__credit_return;
   logic          i__flush;
   logic          o__flush_done;
   logic [CW-1:0] o__credit_count;
   logic          o__credit_error;

   always #5 clk = ~clk;

   fifo_credit_sender #(
      .DATA_WIDTH  (DW),
      .NUM_CREDITS (NC)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .i__data_in_valid  (i__data_in_valid),
      .i__data_in        (i__data_in),
      .o__data_in_ready  (o__data_in_ready),
      .o__data_out_valid (o__data_out_valid),
      .o__data_out       (o__data_out),
      .i__credit_return  (i__credit_return),
      .i__flush          (i__flush),
      .o__flush_done     (o__flush_done),
      .o__credit_count   (o__credit_count),
      .o__credit_error   (o__credit_error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: accepted payloads in, emitted payloads out.
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] out_log[$];

   always @(negedge clk) begin : mon
      logic          acc_now;
      logic          exp_vld;
      logic          prev_acc;
      logic [DW-1:0] d;
      if (!reset) begin
         sb_q.delete();
         prev_acc = 1'b0;
      end else begin
         acc_now = i__data_in_valid && o__data_in_ready;
         if (acc_now) sb_q.push_back(i__data_in);
`ifdef FIFO_CREDIT_SENDER_OUT_REG_EN
         exp_vld = prev_acc;
`else
         exp_vld = acc_now;
`endif
         check_eq("out_vld", {63'd0, o__data_out_valid}, {63'd0, exp_vld});
         if (o__data_out_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
               d = sb_q.pop_front();
               check_eq("out_dat", o__data_out, d);
               out_log.push_back(o__data_out);
            end
         end
         prev_acc = acc_now;
      end
   end

   logic s_acc, s_rdy, s_done;

   // One clock: sample at the falling edge, return 1 time unit after the rising edge.
   task automatic run_cycle();
      @(negedge clk);
      s_acc  = i__data_in_valid && o__data_in_ready;
      s_rdy  = o__data_in_ready;
      s_done = o__flush_done;
      @(posedge clk);
      #1;
      if (s_acc) i__data_in = i__data_in + 64'd1;
   endtask

   int n_acc;
   int n_done;
   int done_idx;
   int rdy_after_done;

   initial begin
      reset            = 1'b0;
      i__data_in_valid = 1'b0;
      i__data_in       = '0;
      i__credit_return = 1'b0;
      i__flush         = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_count",  64'(o__credit_count), 64'd3);
      check_eq("rst_vld",    {63'd0, o__data_out_valid}, 64'd0);
      check_eq("rst_dat",    o__data_out, 64'd0);
      check_eq("rst_done",   {63'd0, o__flush_done}, 64'd0);
      check_eq("rst_err",    {63'd0, o__credit_error}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // 1: three beats then stall
      out_log.delete();
      i__data_in       = 64'hA;
      i__data_in_valid = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         run_cycle();
         if (s_acc) n_acc++;
      end
      check_eq("t1_beats", 64'(n_acc), 64'd3);
      check_eq("t1_rdy",   {63'd0, o__data_in_ready}, 64'd0);
      check_eq("t1_count", 64'(o__credit_count), 64'd0);
      check_eq("t1_nout",  64'(out_log.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < out_log.size()) check_eq("t1_order", out_log[i], 64'hA + 64'(i));
      end
`ifdef FIFO_CREDIT_SENDER_OUT_REG_EN
      check_eq("t1_hold", o__data_out, 64'hC);
`endif

      // 2: single return at zero credits
      i__credit_return = 1'b1;
      run_cycle();
      check_eq("t2_ret_acc", {63'd0, s_acc}, 64'd0);
      i__credit_return = 1'b0;
      run_cycle();
      check_eq("t2_send", {63'd0, s_acc}, 64'd1);
      run_cycle();
      check_eq("t2_stall", {63'd0, s_acc}, 64'd0);
      check_eq("t2_count", 64'(o__credit_count), 64'd0);

      // 3: return every cycle sustains one beat per cycle
      i__credit_return = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         run_cycle();
         if (s_acc) n_acc++;
         check_eq("t3_count", 64'(o__credit_count), 64'd1);
      end
      check_eq("t3_beats", 64'(n_acc), 64'd7);
      i__credit_return = 1'b0;
      i__data_in_valid = 1'b0;

      // 4: send and return together at count 2
      i__credit_return = 1'b1;
      run_cycle();
      check_eq("t4_pre", 64'(o__credit_count), 64'd2);
      i__data_in_valid = 1'b1;
      run_cycle();
      check_eq("t4_send",  {63'd0, s_acc}, 64'd1);
      check_eq("t4_count", 64'(o__credit_count), 64'd2);
      i__data_in_valid = 1'b0;

      // 5: over-return at full credits
      run_cycle();
      check_eq("t5_count3", 64'(o__credit_count), 64'd3);
      check_eq("t5_err0",   {63'd0, o__credit_error}, 64'd0);
      run_cycle();
      check_eq("t5_hold",   64'(o__credit_count), 64'd3);
      check_eq("t5_err1",   {63'd0, o__credit_error}, 64'd1);
      i__credit_return = 1'b0;
      run_cycle();
      check_eq("t5_sticky", {63'd0, o__credit_error}, 64'd1);

      // 6: flush with two beats outstanding; flush arrives with the second send
      i__data_in_valid = 1'b1;
      run_cycle();
      i__flush = 1'b1;
      run_cycle();
      check_eq("t6_flush_send", {63'd0, s_acc}, 64'd1);
      i__flush = 1'b0;
      check_eq("t6_rdy0",  {63'd0, o__data_in_ready}, 64'd0);
      check_eq("t6_count", 64'(o__credit_count), 64'd1);
      i__credit_return = 1'b1;
      run_cycle();
      run_cycle();
      check_eq("t6_wait_acc", {63'd0, s_acc}, 64'd0);
      i__credit_return = 1'b0;
      n_done = 0;
      done_idx = -1;
      rdy_after_done = 0;
      for (int i = 0; i < 8; i++) begin
         run_cycle();
         if (done_idx >= 0 && i == done_idx + 1) rdy_after_done = int'(s_rdy);
         if (s_done) begin
            n_done++;
            if (done_idx < 0) done_idx = i;
         end
      end
      check_eq("t6_ndone",    64'(n_done), 64'd1);
      check_eq("t6_done_at",  64'(done_idx), 64'd1);
      check_eq("t6_rdy_next", 64'(rdy_after_done), 64'd1);
      i__data_in_valid = 1'b0;
      run_cycle();
      run_cycle();
      check_eq("t6_err_still", {63'd0, o__credit_error}, 64'd1);

      // Reset in the middle of a flush aborts it
      i__flush = 1'b1;
      run_cycle();
      i__flush = 1'b0;
      run_cycle();
      check_eq("rf_rdy0", {63'd0, o__data_in_ready}, 64'd0);
      reset = 1'b0;
      run_cycle();
      reset = 1'b1;
      check_eq("rf_count", 64'(o__credit_count), 64'd3);
      check_eq("rf_err",   {63'd0, o__credit_error}, 64'd0);
      n_done = 0;
      for (int i = 0; i < 4; i++) begin
         run_cycle();
         if (s_done) n_done++;
      end
      check_eq("rf_ndone", 64'(n_done), 64'd0);
      check_eq("rf_rdy1",  {63'd0, o__data_in_ready}, 64'd1);
      check_eq("sb_drain", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
